// File: rtl/fix_pkg.sv
// Shared constants, FSM state encoding and byte-class helper for the FIX receive parser.
package fix_pkg;

    localparam logic [7:0] SOH = 8'h01;
    localparam logic [7:0] EQ  = 8'h3D;

    localparam int unsigned TAG_BODYLEN = 9;
    localparam int unsigned TAG_MSGTYPE = 35;
    localparam int unsigned TAG_CHKSUM  = 10;

    localparam int unsigned TAG_W = 14;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned CHK_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        TAG,
        VALUE,
        CHK,
        SKIP
    } state_e;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

endpackage

// File: rtl/fix_dec_acc.sv
// Decimal digit accumulator: clear, load first digit, or acc*10+digit saturating at all-ones.
module fix_dec_acc #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         add_i,
    input  logic [3:0]   digit_i,
    output logic [W-1:0] val_o
);

    localparam int unsigned XW = W + 4;

    logic [W-1:0]  val_q, val_d;
    logic [XW-1:0] mac;

    always_comb begin
        mac   = XW'(val_q) * XW'(10) + XW'(digit_i);
        val_d = val_q;
        if (clr_i) begin
            val_d = '0;
        end else if (load_i) begin
            val_d = W'(digit_i);
        end else if (add_i) begin
            val_d = (mac > XW'({W{1'b1}})) ? {W{1'b1}} : mac[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) val_q <= '0;
        else     val_q <= val_d;
    end

    assign val_o = val_q;

endmodule

// File: rtl/fix_rx_parser.sv
// FIX tag=value byte-stream parser with BodyLength and CheckSum verification.
module fix_rx_parser
    import fix_pkg::*;
#(
    parameter int unsigned MAX_TAG_DIGITS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_message_i,
    input  logic [7:0]  message_i,
    input  logic        end_session_i,
    output logic        tag_valid_o,
    output logic [13:0] tag_o,
    output logic        val_valid_o,
    output logic [7:0]  val_byte_o,
    output logic [7:0]  msg_type_o,
    output logic        msg_done_o,
    output logic        chksum_ok_o,
    output logic        bodylen_ok_o,
    output logic        err_o
);

    localparam int unsigned TCW = $clog2(MAX_TAG_DIGITS + 1);

    state_e            state_q, state_d;
    logic [TCW-1:0]    tag_cnt_q, tag_cnt_d;
    logic [1:0]        chk_cnt_q, chk_cnt_d;
    logic [2:0]        skip_pos_q, skip_pos_d;
    logic [7:0]        sum_q, sum_d, sum_soh_q, sum_soh_d;
    logic [LEN_W-1:0]  body_cnt_q, body_cnt_d, body_soh_q, body_soh_d;
    logic              body_on_q, body_on_d, len_seen_q, len_seen_d;
    logic              first_val_q, first_val_d;
    logic              tag_valid_q, tag_valid_d, val_valid_q, val_valid_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [7:0]        val_byte_q, val_byte_d, msg_type_q, msg_type_d;
    logic              done_q, done_d, chk_ok_q, chk_ok_d, len_ok_q, len_ok_d, err_q, err_d;

    logic              tag_clr, tag_load, tag_add, len_clr, len_add, chk_clr, chk_add, clear_msg;
    logic [TAG_W-1:0]  tag_val;
    logic [LEN_W-1:0]  len_val;
    logic [CHK_W-1:0]  chk_val;
    logic              dig, soh;

    assign dig = is_digit(message_i);
    assign soh = (message_i == SOH);

    fix_dec_acc #(.W(TAG_W)) u_tag_acc (
        .clk(clk), .rst(rst), .clr_i(tag_clr), .load_i(tag_load), .add_i(tag_add),
        .digit_i(message_i[3:0]), .val_o(tag_val)
    );
    fix_dec_acc #(.W(LEN_W)) u_len_acc (
        .clk(clk), .rst(rst), .clr_i(len_clr), .load_i(1'b0), .add_i(len_add),
        .digit_i(message_i[3:0]), .val_o(len_val)
    );
    fix_dec_acc #(.W(CHK_W)) u_chk_acc (
        .clk(clk), .rst(rst), .clr_i(chk_clr), .load_i(1'b0), .add_i(chk_add),
        .digit_i(message_i[3:0]), .val_o(chk_val)
    );

    always_comb begin
        state_d     = state_q;
        tag_cnt_d   = tag_cnt_q;
        chk_cnt_d   = chk_cnt_q;
        skip_pos_d  = skip_pos_q;
        sum_d       = sum_q;
        sum_soh_d   = sum_soh_q;
        body_cnt_d  = body_cnt_q;
        body_soh_d  = body_soh_q;
        body_on_d   = body_on_q;
        len_seen_d  = len_seen_q;
        first_val_d = first_val_q;
        tag_valid_d = 1'b0;
        val_valid_d = 1'b0;
        tag_d       = tag_q;
        val_byte_d  = val_byte_q;
        msg_type_d  = msg_type_q;
        done_d      = 1'b0;
        chk_ok_d    = 1'b0;
        len_ok_d    = 1'b0;
        err_d       = 1'b0;
        tag_clr     = 1'b0;
        tag_load    = 1'b0;
        tag_add     = 1'b0;
        len_clr     = 1'b0;
        len_add     = 1'b0;
        chk_clr     = 1'b0;
        chk_add     = 1'b0;
        clear_msg   = 1'b0;

        if (end_session_i) begin
            // Abort beats any coincident byte
            if (state_q != IDLE) begin
                done_d = 1'b1;
                err_d  = 1'b1;
            end
            state_d   = IDLE;
            clear_msg = 1'b1;
        end else if (new_message_i) begin
            if (state_q == TAG || state_q == VALUE) begin
                sum_d = sum_q + message_i;
                if (body_on_q) body_cnt_d = body_cnt_q + LEN_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (dig) begin
                        state_d    = TAG;
                        tag_load   = 1'b1;
                        tag_cnt_d  = TCW'(1);
                        sum_d      = message_i;
                        msg_type_d = '0;
                    end else if (!soh) begin
                        state_d    = SKIP;
                        skip_pos_d = 3'd0;
                    end
                end
                TAG: begin
                    if (dig && tag_cnt_q != TCW'(MAX_TAG_DIGITS)) begin
                        tag_add   = 1'b1;
                        tag_cnt_d = tag_cnt_q + TCW'(1);
                    end else if (message_i == EQ && tag_cnt_q != TCW'(0)) begin
                        if (tag_val == TAG_W'(TAG_CHKSUM)) begin
                            state_d   = CHK;
                            chk_clr   = 1'b1;
                            chk_cnt_d = 2'd0;
                        end else begin
                            state_d     = VALUE;
                            tag_valid_d = 1'b1;
                            tag_d       = tag_val;
                            first_val_d = 1'b1;
                            if (tag_val == TAG_W'(TAG_BODYLEN)) begin
                                len_clr    = 1'b1;
                                len_seen_d = 1'b1;
                            end
                        end
                    end else begin
                        state_d    = SKIP;
                        skip_pos_d = soh ? 3'd1 : 3'd0;
                    end
                end
                VALUE: begin
                    if (soh) begin
                        // Snapshot sum/length at each SOH; the last one before "10=" is what gets checked
                        state_d   = TAG;
                        tag_clr   = 1'b1;
                        tag_cnt_d = '0;
                        sum_soh_d = sum_q + message_i;
                        if (body_on_q) body_soh_d = body_cnt_q + LEN_W'(1);
                        if (tag_val == TAG_W'(TAG_BODYLEN)) begin
                            body_on_d  = 1'b1;
                            body_cnt_d = '0;
                        end
                    end else begin
                        val_valid_d = 1'b1;
                        val_byte_d  = message_i;
                        first_val_d = 1'b0;
                        if (first_val_q && tag_val == TAG_W'(TAG_MSGTYPE)) msg_type_d = message_i;
                        if (dig && tag_val == TAG_W'(TAG_BODYLEN)) len_add = 1'b1;
                    end
                end
                CHK: begin
                    if (dig && chk_cnt_q != 2'd3) begin
                        chk_add   = 1'b1;
                        chk_cnt_d = chk_cnt_q + 2'd1;
                    end else if (soh && chk_cnt_q == 2'd3) begin
                        done_d    = 1'b1;
                        chk_ok_d  = (chk_val == CHK_W'(sum_soh_q));
                        len_ok_d  = len_seen_q && (len_val == body_soh_q);
                        state_d   = IDLE;
                        clear_msg = 1'b1;
                    end else begin
                        state_d    = SKIP;
                        skip_pos_d = soh ? 3'd1 : 3'd0;
                    end
                end
                SKIP: begin
                    // skip_pos: 1 field start, 2 '1', 3 '0', 4 '=', 5..7 checksum digits seen
                    if (soh) begin
                        if (skip_pos_q == 3'd7) begin
                            done_d    = 1'b1;
                            err_d     = 1'b1;
                            state_d   = IDLE;
                            clear_msg = 1'b1;
                        end else begin
                            skip_pos_d = 3'd1;
                        end
                    end else begin
                        case (skip_pos_q)
                            3'd1:                skip_pos_d = (message_i == 8'h31) ? 3'd2 : 3'd0;
                            3'd2:                skip_pos_d = (message_i == 8'h30) ? 3'd3 : 3'd0;
                            3'd3:                skip_pos_d = (message_i == EQ)    ? 3'd4 : 3'd0;
                            3'd4, 3'd5, 3'd6:    skip_pos_d = dig ? skip_pos_q + 3'd1 : 3'd0;
                            default:             skip_pos_d = 3'd0;
                        endcase
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (clear_msg) begin
            tag_cnt_d   = '0;
            chk_cnt_d   = '0;
            skip_pos_d  = '0;
            sum_d       = '0;
            sum_soh_d   = '0;
            body_cnt_d  = '0;
            body_soh_d  = '0;
            body_on_d   = 1'b0;
            len_seen_d  = 1'b0;
            first_val_d = 1'b0;
            tag_clr     = 1'b1;
            len_clr     = 1'b1;
            chk_clr     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tag_cnt_q   <= '0;
            chk_cnt_q   <= '0;
            skip_pos_q  <= '0;
            sum_q       <= '0;
            sum_soh_q   <= '0;
            body_cnt_q  <= '0;
            body_soh_q  <= '0;
            body_on_q   <= 1'b0;
            len_seen_q  <= 1'b0;
            first_val_q <= 1'b0;
            tag_valid_q <= 1'b0;
            val_valid_q <= 1'b0;
            tag_q       <= '0;
            val_byte_q  <= '0;
            msg_type_q  <= '0;
            done_q      <= 1'b0;
            chk_ok_q    <= 1'b0;
            len_ok_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_cnt_q   <= tag_cnt_d;
            chk_cnt_q   <= chk_cnt_d;
            skip_pos_q  <= skip_pos_d;
            sum_q       <= sum_d;
            sum_soh_q   <= sum_soh_d;
            body_cnt_q  <= body_cnt_d;
            body_soh_q  <= body_soh_d;
            body_on_q   <= body_on_d;
            len_seen_q  <= len_seen_d;
            first_val_q <= first_val_d;
            tag_valid_q <= tag_valid_d;
            val_valid_q <= val_valid_d;
            tag_q       <= tag_d;
            val_byte_q  <= val_byte_d;
            msg_type_q  <= msg_type_d;
            done_q      <= done_d;
            chk_ok_q    <= chk_ok_d;
            len_ok_q    <= len_ok_d;
            err_q       <= err_d;
        end
    end

    assign tag_valid_o  = tag_valid_q;
    assign tag_o        = tag_q;
    assign val_valid_o  = val_valid_q;
    assign val_byte_o   = val_byte_q;
    assign msg_type_o   = msg_type_q;
    assign msg_done_o   = done_q;
    assign chksum_ok_o  = chk_ok_q;
    assign bodylen_ok_o = len_ok_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_fix_rx_parser.sv
// Directed bench for fix_rx_parser: table of whole messages plus abort/reset/error sequences.
module tb_fix_rx_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_message_i;
    logic [7:0]  message_i;
    logic        end_session_i;
    logic        tag_valid_o;
    logic [13:0] tag_o;
    logic        val_valid_o;
    logic [7:0]  val_byte_o;
    logic [7:0]  msg_type_o;
    logic        msg_done_o;
    logic        chksum_ok_o;
    logic        bodylen_ok_o;
    logic        err_o;

    fix_rx_parser #(.MAX_TAG_DIGITS(5)) dut (
        .clk(clk), .rst(rst), .new_message_i(new_message_i), .message_i(message_i),
        .end_session_i(end_session_i), .tag_valid_o(tag_valid_o), .tag_o(tag_o),
        .val_valid_o(val_valid_o), .val_byte_o(val_byte_o), .msg_type_o(msg_type_o),
        .msg_done_o(msg_done_o), .chksum_ok_o(chksum_ok_o), .bodylen_ok_o(bodylen_ok_o),
        .err_o(err_o)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int   n_tag = 0, tag_sum = 0, n_val = 0, n_done = 0;
    logic l_chk = 1'b0, l_len = 1'b0, l_err = 1'b0;

    always @(negedge clk) begin
        if (tag_valid_o) begin
            n_tag   <= n_tag + 1;
            tag_sum <= tag_sum + int'(tag_o);
        end
        if (val_valid_o) n_val <= n_val + 1;
        if (msg_done_o) begin
            n_done <= n_done + 1;
            l_chk  <= chksum_ok_o;
            l_len  <= bodylen_ok_o;
            l_err  <= err_o;
        end
    end

    typedef struct {
        int         body_sel;
        int         len_adj;
        int         chk_adj;
        bit         with_len;
        bit         e_chk;
        bit         e_len;
        bit         e_err;
        logic [7:0] e_mt;
        int         e_ntag;
        int         e_tagsum;
    } vec_t;

    vec_t        vecs[5];
    string       bodies[3];
    logic [7:0]  msg_q[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_str(input string s);
        logic [7:0] c;
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            msg_q.push_back((c == 8'h7C) ? 8'h01 : c);
        end
    endtask

    // Frames a body with header and trailer; '|' stands for SOH. Also returns the value-byte count.
    task automatic build_msg(input string body, input int len_adj, input int chk_adj,
                             input bit with_len, output int nvals);
        string      s;
        int         sum;
        bit         in_val;
        logic [7:0] c;
        s = "8=FIX.4.2|";
        if (with_len) s = {s, $sformatf("9=%0d|", body.len() + len_adj)};
        s = {s, body};
        sum = 0; nvals = 0; in_val = 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == 8'h7C) c = 8'h01;
            sum += int'(c);
            if (c == 8'h01)      in_val = 1'b0;
            else if (in_val)     nvals++;
            else if (c == 8'h3D) in_val = 1'b1;
        end
        s = {s, $sformatf("10=%03d|", (sum + chk_adj) % 256)};
        push_str(s);
    endtask

    task automatic send_b(input logic [7:0] b);
        @(negedge clk);
        new_message_i = 1'b1;
        message_i     = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            new_message_i = 1'b0;
            message_i     = 8'h00;
        end
    endtask

    task automatic send_msg();
        foreach (msg_q[i]) send_b(msg_q[i]);
        idle(3);
    endtask

    initial begin
        int d_done, d_tag, d_tsum, d_val, nv;

        bodies[0] = "35=A|";
        bodies[1] = "35=0|49=SENDERCOMPID|56=TARGETCOMPID|34=12|52=20240101-12:00:00|";
        bodies[2] = "35=5|";
        vecs[0] = '{0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h41, 3, 52};
        vecs[1] = '{0, 0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h41, 3, 52};
        vecs[2] = '{0, 2, 0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h41, 3, 52};
        vecs[3] = '{1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h30, 7, 243};
        vecs[4] = '{2, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h35, 2, 43};

        rst = 1'b1; new_message_i = 1'b0; message_i = 8'h00; end_session_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tag_valid", int'(tag_valid_o), 0);
        check("rst_val_valid", int'(val_valid_o), 0);
        check("rst_done",      int'(msg_done_o), 0);
        check("rst_tag",       int'(tag_o), 0);
        check("rst_msg_type",  int'(msg_type_o), 0);
        check("rst_flags",     int'({chksum_ok_o, bodylen_ok_o, err_o}), 0);
        rst = 1'b0;
        idle(2);

        for (int v = 0; v < 5; v++) begin
            d_done = n_done; d_tag = n_tag; d_tsum = tag_sum; d_val = n_val;
            build_msg(bodies[vecs[v].body_sel], vecs[v].len_adj, vecs[v].chk_adj,
                      vecs[v].with_len, nv);
            send_msg();
            check($sformatf("v%0d_done", v),    n_done - d_done, 1);
            check($sformatf("v%0d_chk", v),     int'(l_chk), int'(vecs[v].e_chk));
            check($sformatf("v%0d_len", v),     int'(l_len), int'(vecs[v].e_len));
            check($sformatf("v%0d_err", v),     int'(l_err), int'(vecs[v].e_err));
            check($sformatf("v%0d_mtype", v),   int'(msg_type_o), int'(vecs[v].e_mt));
            check($sformatf("v%0d_ntag", v),    n_tag - d_tag, vecs[v].e_ntag);
            check($sformatf("v%0d_tagsum", v),  tag_sum - d_tsum, vecs[v].e_tagsum);
            check($sformatf("v%0d_nval", v),    n_val - d_val, nv);
        end

        // Malformed tag mid-message: skipped to trailer, error reported, no further values
        d_done = n_done; d_tag = n_tag; d_val = n_val;
        push_str("8=FIX.4.2|9=5|12a=X|35=A|10=000|");
        send_msg();
        check("badtag_done", n_done - d_done, 1);
        check("badtag_err",  int'(l_err), 1);
        check("badtag_chk",  int'(l_chk), 0);
        check("badtag_len",  int'(l_len), 0);
        check("badtag_nval", n_val - d_val, 8);
        check("badtag_ntag", n_tag - d_tag, 2);

        // Abort during a value, coincident with a byte that must be dropped
        d_done = n_done; d_val = n_val;
        send_b(8'h38); send_b(8'h3D); send_b(8'h46); send_b(8'h49);
        @(negedge clk);
        end_session_i = 1'b1; new_message_i = 1'b1; message_i = 8'h58;
        @(negedge clk);
        check("abort_done_next", int'(msg_done_o), 1);
        check("abort_err",       int'(err_o), 1);
        end_session_i = 1'b0; new_message_i = 1'b0;
        idle(2);
        check("abort_ndone", n_done - d_done, 1);
        check("abort_nval",  n_val - d_val, 2);

        d_done = n_done;
        build_msg(bodies[0], 0, 0, 1'b1, nv);
        send_msg();
        check("post_abort_done", n_done - d_done, 1);
        check("post_abort_ok",   int'({l_chk, l_len, l_err}), 6);

        // end_session while idle produces no pulse
        d_done = n_done;
        @(negedge clk); end_session_i = 1'b1;
        @(negedge clk); end_session_i = 1'b0;
        idle(2);
        check("idle_abort_nodone", n_done - d_done, 0);

        // Four checksum digits: parser waits in skip until aborted
        d_done = n_done;
        build_msg(bodies[0], 0, 0, 1'b1, nv);
        void'(msg_q.pop_back());
        msg_q.push_back(8'h34);
        msg_q.push_back(8'h01);
        send_msg();
        check("chk4_nodone", n_done - d_done, 0);
        @(negedge clk); end_session_i = 1'b1;
        @(negedge clk);
        check("chk4_abort_done", int'(msg_done_o), 1);
        check("chk4_abort_err",  int'(err_o), 1);
        end_session_i = 1'b0;
        idle(2);

        // Reset mid-message discards it silently
        d_done = n_done;
        send_b(8'h38); send_b(8'h3D); send_b(8'h46); send_b(8'h49); send_b(8'h58);
        @(negedge clk); rst = 1'b1; new_message_i = 1'b0;
        @(negedge clk); rst = 1'b0;
        idle(3);
        check("rst_mid_nodone",  n_done - d_done, 0);
        check("rst_mid_tag",     int'(tag_o), 0);
        check("rst_mid_valbyte", int'(val_byte_o), 0);

        d_done = n_done;
        build_msg(bodies[1], 0, 0, 1'b1, nv);
        send_msg();
        check("post_rst_done", n_done - d_done, 1);
        check("post_rst_ok",   int'({l_chk, l_len, l_err}), 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
